// File: rtl/serial_pattern_source_pkg.sv
// Shared types and sizing for the serial pattern source and its word FIFO.
package serial_pattern_source_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = $clog2(DEF_DEPTH) + 1;

    // Occupancy must represent 0..depth inclusive, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_pattern_source_fifo.sv
// Circular word buffer with occupancy count; pushes while full are dropped.
module pattern_fifo
    import serial_pattern_source_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = idx_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop in the same cycle does not make room for a push while full.
    assign w_push_ok = push && !full && !rst;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/serial_pattern_source.sv
// Streams buffered pattern words MSB-first as a gap-free serial bit stream.
module serial_pattern_source
    import serial_pattern_source_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic             full,
    output logic             busy,
    output logic             out,
    output logic             out_valid,
    output logic             done
);

    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int BCNT_W = idx_w(WIDTH);

    state_t            r_state;
    logic [WIDTH-1:0]  r_shreg;
    logic [BCNT_W-1:0] r_bitcnt;
    logic              r_done;
    logic [WIDTH-1:0]  w_dout;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_last;
    logic              w_pop;

    pattern_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_dout),
        .count (w_count),
        .full  (full),
        .empty (w_empty)
    );

    assign w_last = (r_bitcnt == BCNT_W'(WIDTH - 1));

    // Only words already buffered before this edge can chain onto the stream.
    assign w_pop = ((r_state == IDLE) && start && (w_count != '0)) ||
                   ((r_state == SHIFT) && w_last && !w_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shreg  <= w_dout;
                        r_bitcnt <= '0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_bitcnt <= '0;
                        if (w_pop) begin
                            r_shreg <= w_dout;
                        end else begin
                            r_shreg <= '0;
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_shreg  <= r_shreg << 1;
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out       = (r_state == SHIFT) && r_shreg[WIDTH-1];
    assign out_valid = (r_state == SHIFT);
    assign busy      = (r_state == SHIFT);
    assign done      = r_done;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Directed bench for serial_pattern_source: vector table plus multi-cycle sequences.
module tb_serial_pattern_source;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start;
    logic       full;
    logic       busy;
    logic       out;
    logic       out_valid;
    logic       done;

    int total = 0;
    int bad   = 0;

    serial_pattern_source #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .start     (start),
        .full      (full),
        .busy      (busy),
        .out       (out),
        .out_valid (out_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Inputs applied before an edge, outputs expected just after it.
    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       start;
        logic [4:0] e;   // {out, out_valid, busy, full, done}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic w, input logic [7:0] d,
                               input logic s, input logic [4:0] e);
        vec_t x;
        x.rst = r; x.wr_en = w; x.wr_data = d; x.start = s; x.e = e;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] d, input logic s);
        rst = r; wr_en = w; wr_data = d; start = s;
    endtask

    task automatic chk_bit(input string nm, input logic b);
        chk({nm, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, ".out"},   {31'd0, out},       {31'd0, b});
        chk({nm, ".done"},  {31'd0, done},      32'd0);
    endtask

    initial begin
        logic [31:0] s3;
        logic [7:0]  w5;
        logic [7:0]  w6a;
        logic [7:0]  w6b;
        int          dones;

        drive(1'b1, 1'b0, 8'h00, 1'b0);

        // Reset and idle
        vecs.push_back(v(1, 0, 8'h00, 0, 5'b00000));
        for (int i = 0; i < 3; i++) vecs.push_back(v(0, 0, 8'h00, 0, 5'b00000));
        // Single word 0xE6 -> 1,1,1,0,0,1,1,0 then done; start mid-stream ignored
        vecs.push_back(v(0, 1, 8'hE6, 0, 5'b00000));
        vecs.push_back(v(0, 0, 8'h00, 1, 5'b11100));
        vecs.push_back(v(0, 0, 8'h00, 0, 5'b11100));
        vecs.push_back(v(0, 0, 8'h00, 1, 5'b11100));
        vecs.push_back(v(0, 0, 8'h00, 0, 5'b01100));
        vecs.push_back(v(0, 0, 8'h00, 0, 5'b01100));
        vecs.push_back(v(0, 0, 8'h00, 0, 5'b11100));
        vecs.push_back(v(0, 0, 8'h00, 0, 5'b11100));
        vecs.push_back(v(0, 0, 8'h00, 0, 5'b01100));
        vecs.push_back(v(0, 0, 8'h00, 0, 5'b00001));
        vecs.push_back(v(0, 0, 8'h00, 0, 5'b00000));
        // Start with an empty buffer
        vecs.push_back(v(0, 0, 8'h00, 1, 5'b00000));
        vecs.push_back(v(0, 0, 8'h00, 0, 5'b00000));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].wr_en, vecs[i].wr_data, vecs[i].start);
            tick();
            chk($sformatf("row%0d.out", i),   {31'd0, out},       {31'd0, vecs[i].e[4]});
            chk($sformatf("row%0d.valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e[3]});
            chk($sformatf("row%0d.busy", i),  {31'd0, busy},      {31'd0, vecs[i].e[2]});
            chk($sformatf("row%0d.full", i),  {31'd0, full},      {31'd0, vecs[i].e[1]});
            chk($sformatf("row%0d.done", i),  {31'd0, done},      {31'd0, vecs[i].e[0]});
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("reset.count", {28'd0, dut.w_count}, 32'd0);

        // Four words fill the buffer; fifth write is dropped; 32 gap-free bits
        s3 = 32'hE733FF00;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, s3[31-8*i -: 8], 1'b0);
            tick();
        end
        chk("fill.full",  {31'd0, full},         32'd1);
        chk("fill.count", {28'd0, dut.w_count},  32'd4);
        drive(1'b0, 1'b1, 8'hAA, 1'b0);
        tick();
        chk("drop.full",  {31'd0, full},         32'd1);
        chk("drop.count", {28'd0, dut.w_count},  32'd4);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("b2b.count", {28'd0, dut.w_count}, 32'd3);
        chk_bit("b2b.bit0", s3[31]);
        for (int i = 1; i < 32; i++) begin
            tick();
            chk_bit($sformatf("b2b.bit%0d", i), s3[31-i]);
        end
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dones++;
            chk($sformatf("b2b.tail%0d.valid", i), {31'd0, out_valid}, 32'd0);
        end
        chk("b2b.done_pulses", dones, 32'd1);
        chk("b2b.busy", {31'd0, busy}, 32'd0);

        // Reset during the 4th bit of 0xE7, with a write in the reset cycle
        w5 = 8'hE7;
        drive(1'b0, 1'b1, w5, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk_bit("abort.bit0", w5[7]);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_bit($sformatf("abort.bit%0d", i), w5[7-i]);
        end
        drive(1'b1, 1'b1, 8'h55, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("abort.valid", {31'd0, out_valid},    32'd0);
        chk("abort.busy",  {31'd0, busy},         32'd0);
        chk("abort.count", {28'd0, dut.w_count},  32'd0);
        chk("abort.done",  {31'd0, done},         32'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || out_valid) dones++;
        end
        chk("abort.quiet", dones, 32'd0);

        // Write during last bit of 0x0F does not chain; it streams on next start
        w6a = 8'h0F;
        w6b = 8'hC3;
        drive(1'b0, 1'b1, w6a, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk_bit("late.a0", w6a[7]);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_bit($sformatf("late.a%0d", i), w6a[7-i]);
        end
        drive(1'b0, 1'b1, w6b, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("late.done",  {31'd0, done},        32'd1);
        chk("late.valid", {31'd0, out_valid},   32'd0);
        chk("late.count", {28'd0, dut.w_count}, 32'd1);
        tick();
        chk("late.done_clr", {31'd0, done}, 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk_bit("late.b0", w6b[7]);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_bit($sformatf("late.b%0d", i), w6b[7-i]);
        end
        tick();
        chk("late.done2", {31'd0, done}, 32'd1);
        chk("late.busy2", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
